// File: rtl/sat_pkg.sv
// Shared definitions for the DPLL decision scheduler: FSM encoding and
// decision stack entry field widths.
package sat_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECIDE,
    S_WAIT_DEC,
    S_PROPAGATE,
    S_WAIT_BCP,
    S_BACKTRACK,
    S_FLIP,
    S_DONE
  } sched_state_e;

  localparam int VALUE_W   = 1;
  localparam int FLIPPED_W = 1;

endpackage

// File: rtl/decision_stack.sv
// LIFO of decisions: one-hot variable, polarity and flipped flag per level.
// Only the level counter and flipped bits are reset; data above level is never read.
module decision_stack
  import sat_pkg::*;
#(
  parameter int var_num       = 8,
  parameter int address_width = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flip,
  input  logic [var_num-1:0]       push_var,
  input  logic [VALUE_W-1:0]       push_val,
  output logic [var_num-1:0]       top_var,
  output logic [VALUE_W-1:0]       top_val,
  output logic [FLIPPED_W-1:0]     top_flipped,
  output logic [address_width:0]   level
);

  logic [var_num-1:0]   var_q  [var_num];
  logic [VALUE_W-1:0]   val_q  [var_num];
  logic [FLIPPED_W-1:0] flip_q [var_num];
  logic [address_width:0]   level_q;
  logic [address_width-1:0] push_idx, top_idx;

  // At level==var_num the low bits wrap to 0, so top_idx still lands on the last entry.
  assign push_idx    = level_q[address_width-1:0];
  assign top_idx     = level_q[address_width-1:0] - 1'b1;
  assign top_var     = var_q[top_idx];
  assign top_val     = val_q[top_idx];
  assign top_flipped = flip_q[top_idx];
  assign level       = level_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      level_q <= '0;
      for (int i = 0; i < var_num; i++) flip_q[i] <= '0;
    end else if (clear) begin
      level_q <= '0;
    end else if (push) begin
      flip_q[push_idx] <= '0;
      level_q          <= level_q + 1'b1;
    end else if (pop) begin
      flip_q[top_idx] <= '0;
      level_q         <= level_q - 1'b1;
    end else if (flip) begin
      flip_q[top_idx] <= '1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !clear) begin
      if (push) begin
        var_q[push_idx] <= push_var;
        val_q[push_idx] <= push_val;
      end else if (!pop && flip) begin
        val_q[top_idx] <= ~val_q[top_idx];
      end
    end
  end

endmodule

// File: rtl/decision_scheduler.sv
// DPLL control FSM: sequences decisions, BCP requests and chronological
// backtracking over a decision_stack. All outputs are registered.
module decision_scheduler
  import sat_pkg::*;
#(
  parameter int var_num       = 8,
  parameter int address_width = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  output logic                   decision_en,
  input  logic [var_num-1:0]     var_out,
  input  logic                   assignment,
  input  logic                   decision_finish,
  input  logic                   all_assigned,
  output logic                   bcp_en,
  output logic [var_num-1:0]     bcp_var,
  output logic                   bcp_value,
  input  logic                   bcp_done,
  input  logic                   bcp_conflict,
  output logic                   unassign_en,
  output logic [address_width:0] unassign_level,
  output logic [address_width:0] level,
  output logic                   busy,
  output logic                   sat,
  output logic                   unsat
);

  localparam logic [address_width:0] FULL = (address_width+1)'(var_num);

  sched_state_e state;
  logic [var_num-1:0]   top_var;
  logic [VALUE_W-1:0]   top_val;
  logic [FLIPPED_W-1:0] top_flipped;
  logic st_clear, st_push, st_pop, st_flip, solved;

  assign st_clear = (state == S_IDLE) && start;
  assign st_push  = (state == S_WAIT_DEC) && decision_finish;
  assign st_pop   = (state == S_BACKTRACK) && (level != '0) && top_flipped[0];
  assign st_flip  = (state == S_FLIP);
  assign solved   = all_assigned || (level == FULL);

  decision_stack #(
    .var_num       (var_num),
    .address_width (address_width)
  ) u_stack (
    .clock       (clock),
    .reset       (reset),
    .clear       (st_clear),
    .push        (st_push),
    .pop         (st_pop),
    .flip        (st_flip),
    .push_var    (var_out),
    .push_val    (assignment),
    .top_var     (top_var),
    .top_val     (top_val),
    .top_flipped (top_flipped),
    .level       (level)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      decision_en    <= 1'b0;
      bcp_en         <= 1'b0;
      bcp_var        <= '0;
      bcp_value      <= 1'b0;
      unassign_en    <= 1'b0;
      unassign_level <= '0;
      busy           <= 1'b0;
      sat            <= 1'b0;
      unsat          <= 1'b0;
    end else begin
      decision_en <= 1'b0;
      bcp_en      <= 1'b0;
      unassign_en <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state <= S_DECIDE;
          sat   <= 1'b0;
          unsat <= 1'b0;
          busy  <= 1'b1;
        end
        S_DECIDE: if (solved) begin
          state <= S_DONE;
          sat   <= 1'b1;
        end else begin
          decision_en <= 1'b1;
          state       <= S_WAIT_DEC;
        end
        // The pushed entry becomes the stack top, so forward it straight to BCP.
        S_WAIT_DEC: if (decision_finish) begin
          bcp_en    <= 1'b1;
          bcp_var   <= var_out;
          bcp_value <= assignment;
          state     <= S_PROPAGATE;
        end
        S_PROPAGATE: state <= S_WAIT_BCP;
        // A clean BCP folds the DECIDE evaluation into this edge to keep the
        // bcp_done -> decision_en turnaround at one cycle.
        S_WAIT_BCP: if (bcp_done) begin
          if (bcp_conflict) begin
            state <= S_BACKTRACK;
          end else if (solved) begin
            state <= S_DONE;
            sat   <= 1'b1;
          end else begin
            decision_en <= 1'b1;
            state       <= S_WAIT_DEC;
          end
        end
        S_BACKTRACK: if (level == '0) begin
          state <= S_DONE;
          unsat <= 1'b1;
        end else begin
          unassign_en    <= 1'b1;
          unassign_level <= level - 1'b1;
          if (!top_flipped[0]) state <= S_FLIP;
        end
        S_FLIP: begin
          bcp_en    <= 1'b1;
          bcp_var   <= top_var;
          bcp_value <= ~top_val[0];
          state     <= S_PROPAGATE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
